// File: rtl/seg7_msg_sched.sv
// seg7_msg_sched: four-digit 7-segment display scheduler.
// Shows base_chars by default; a message request takes over the display for
// HOLD_TICKS display ticks, then the display falls back to base_chars.
//
// Handshake: the requester raises msg_req with msg_chars valid and holds both
// until it sees the single-cycle msg_ack pulse. A request is taken whenever
// msg_req=1 and msg_ack=0 in the same sampled cycle, so the still-high
// msg_req in the ack cycle never produces a second acceptance.
module seg7_msg_sched #(
   parameter int TICK_DIV   = 27000,
   parameter int HOLD_TICKS = 2000
) (
   input  logic        clk27,
   input  logic        reset,
   input  logic [15:0] base_chars,
   input  logic        msg_req,
   input  logic [15:0] msg_chars,
   output logic        msg_ack,
   output logic [15:0] disp_chars,
   output logic        msg_active
);

   // A hold of zero ticks is treated as one tick.
   localparam int HOLD_EFF = (HOLD_TICKS < 1) ? 1 : HOLD_TICKS;
   localparam int PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int HW       = $clog2(HOLD_EFF + 1);

   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_EFF);
   localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SHOW = 1'b1
   } state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [15:0]   disp_q, disp_d;
   logic          ack_q, ack_d;
   logic          active_q, active_d;

   logic          tick;
   logic          accept;

   assign tick   = (presc_q == PRESC_MAX);
   assign accept = msg_req && !ack_q;

   // State register; reset blanks all digits and drops any message.
   always_ff @(posedge clk27 or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         presc_q  <= '0;
         hold_q   <= '0;
         disp_q   <= 16'hFFFF;
         ack_q    <= 1'b0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         presc_q  <= presc_d;
         hold_q   <= hold_d;
         disp_q   <= disp_d;
         ack_q    <= ack_d;
         active_q <= active_d;
      end
   end

   // Next-state logic; a new acceptance outranks an expiring tick.
   always_comb begin
      state_d  = state_q;
      presc_d  = tick ? '0 : presc_q + PW'(1);
      hold_d   = hold_q;
      disp_d   = disp_q;
      ack_d    = 1'b0;
      active_d = active_q;

      if (accept) begin
         // Fresh message (or pre-emption): restart the whole hold window.
         state_d  = ST_SHOW;
         presc_d  = '0;
         hold_d   = HOLD_INIT;
         disp_d   = msg_chars;
         ack_d    = 1'b1;
         active_d = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               disp_d   = base_chars;
               active_d = 1'b0;
            end
            ST_SHOW: begin
               if (tick) begin
                  if (hold_q > HOLD_ONE) begin
                     hold_d = hold_q - HW'(1);
                  end else begin
                     state_d  = ST_IDLE;
                     hold_d   = '0;
                     disp_d   = base_chars;
                     active_d = 1'b0;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   assign msg_ack    = ack_q;
   assign disp_chars = disp_q;
   assign msg_active = active_q;

endmodule

// File: doc/seg7_msg_sched.md
SEG7_MSG_SCHED -- requirements
Module: seg7_msg_sched

Interface
REQ-001 Parameter TICK_DIV, default 27000, clk27 cycles per display tick (1 ms at 27 MHz); legal range >= 2.
REQ-002 Parameter HOLD_TICKS, default 2000, number of ticks a message is held on the display; value 0 SHALL behave as 1.
REQ-003 clk27  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 base_chars  input  16  default display, four 4-bit char_ids; [15:12] = leftmost digit.
REQ-006 msg_req  input  1  requester asks to show msg_chars temporarily; held high until msg_ack.
REQ-007 msg_chars  input  16  message char_ids, same packing as base_chars; valid while msg_req is high.
REQ-008 msg_ack  output  1  one-cycle pulse confirming message acceptance.
REQ-009 disp_chars  output  16  registered char_ids driving four 7-segment decoders; 4'hF = blank digit.
REQ-010 msg_active  output  1  high while a message owns the display.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE (base display) and SHOW (message display).
REQ-012 A free-running prescaler SHALL count 0..TICK_DIV-1, assert an internal tick when equal to TICK_DIV-1, and wrap to 0 on that cycle.
REQ-013 In IDLE, disp_chars SHALL load base_chars every cycle (1-cycle latency).
REQ-014 The block SHALL accept a request when msg_req=1 and msg_ack=0 in the sampled cycle, in either state.
REQ-015 On acceptance: state->SHOW, disp_chars<-msg_chars, prescaler<-0, hold counter<-HOLD_TICKS, msg_ack<-1, msg_active<-1, all on the same edge.
REQ-016 msg_ack SHALL be high for exactly one cycle per acceptance; msg_req high in the cycle msg_ack is high SHALL be ignored.
REQ-017 A request accepted in SHOW SHALL pre-empt: the new msg_chars replace the display and the hold timer restarts in full.
REQ-018 In SHOW, disp_chars SHALL hold the latched message; base_chars changes SHALL NOT affect it.
REQ-019 In SHOW, each tick with hold counter > 1 SHALL decrement it; a tick with hold counter = 1 SHALL return to IDLE.
REQ-020 On return to IDLE: disp_chars<-base_chars, msg_active<-0 on the same edge.
REQ-021 Without pre-emption, SHOW SHALL last exactly HOLD_TICKS*TICK_DIV cycles (1*TICK_DIV when HOLD_TICKS=0).
REQ-022 Acceptance in the same cycle as an expiring tick SHALL take priority: remain in SHOW with the new message and a full hold.
REQ-023 Hold counter width SHALL fit HOLD_TICKS; prescaler width SHALL fit TICK_DIV-1; no overflow or wrap of the hold counter.

Reset
REQ-024 While reset=1: state=IDLE, prescaler=0, hold counter=0, msg_ack=0, msg_active=0, disp_chars=16'hFFFF (all blank).
REQ-025 Reset asserted mid-SHOW SHALL abort the message immediately; after release the block SHALL display base_chars from the first clock edge onward.
REQ-026 A msg_req held high across reset release SHALL be accepted on the first edge after release.

Verification (TICK_DIV=4, HOLD_TICKS=3 unless noted)
REQ-027 Reset, base_chars=16'h1234 -> disp_chars=16'hFFFF during reset; 16'h1234 one cycle after release; msg_ack=0, msg_active=0.
REQ-028 IDLE, msg_req=1, msg_chars=16'hBC0E, held until ack -> next edge: disp_chars=16'hBC0E, msg_ack=1 for one cycle, msg_active=1; after 12 cycles disp_chars=base_chars, msg_active=0.
REQ-029 During SHOW change base_chars to 16'h5678 -> disp_chars stays 16'hBC0E until expiry, then 16'h5678.
REQ-030 Second request (16'hA9A9) 6 cycles into SHOW -> ack pulse, display 16'hA9A9, SHOW ends 12 cycles after second acceptance.
REQ-031 Second request sampled on the expiring tick cycle -> no IDLE cycle, display switches directly to new message, full 12-cycle hold.
REQ-032 Reset asserted 5 cycles into SHOW -> disp_chars=16'hFFFF, msg_active=0 immediately; msg_req kept high across release -> accepted on first edge after release.
